mux2_rr_arbiter: RTL and testbench
==================================

// Module: mux2_rr_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one n-bit 2:1 datapath mux between two requesters (A, B).
//  Uses valid/ready handshakes on both inputs and on the output; the winner's data goes through a single output register.
//  Sits between two producers (e.g. ALU result / memory load) and one shared consumer (register write-back bus).
// PARAMETERS
//  n  16  data width of both request channels and the output
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  a_valid    in   1  requester A has a beat
//  a_data     in   n  requester A payload
//  a_ready    out  1  A beat accepted this cycle (a_valid & a_ready)
//  b_valid    in   1  requester B has a beat
//  b_data     in   n  requester B payload
//  b_ready    out  1  B beat accepted this cycle
//  out_valid  out  1  output register holds a beat
//  out_data   out  n  registered payload
//  out_src    out  1  source of out_data: 1=A, 0=B (matches mux select polarity)
//  out_ready  in   1  consumer accepts the beat (out_valid & out_ready)
//  a_lock     in   1  [MUX2_ARB_BURST_EN only] keep the grant after this A beat
//  b_lock     in   1  [MUX2_ARB_BURST_EN only] keep the grant after this B beat
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0, out_data=0, out_src=0, a_ready=b_ready=0 (outputs gated by rst_n), state=EMPTY, last_src=B (A wins first tie), lock owner cleared. A beat in flight is dropped.
//  - FSM (output register), 2 states:
//      EMPTY: load_en = winner valid; on load -> FULL.
//      FULL : drain = out_ready. load_en = drain & winner valid.
//             drain & load -> FULL (back-to-back); drain & !load -> EMPTY; !drain -> FULL, hold all outputs stable.
//  - can_load = (state==EMPTY) | out_ready. a_ready/b_ready are combinational: granted & can_load.
//  - Grant: only A valid -> A; only B valid -> B; both valid -> requester != last_src; neither -> no grant, both ready=0.
//  - On accept: out_data <= mux(select=grant_A, A data, B data); out_src <= grant_A; last_src <= grant source.
//  - Latency: accept in cycle t -> out_valid=1 in cycle t+1. Throughput: 1 beat/cycle with out_ready held high.
//  - Never a_ready & b_ready in the same cycle. A requester holds valid/data stable until ready. Dropping valid without ready is legal and causes no accept.
//  - No combinational path out_ready->out_valid. The path out_ready->a_ready/b_ready is allowed.
// CONFIGURATION
//  MUX2_ARB_BURST_EN defined:
//   - a_lock/b_lock ports exist.
//   - Accepting a beat with lock=1 records that source as lock owner.
//   - While owned, only the owner is granted; the other requester gets ready=0 even if the owner is idle.
//   - Accepting an owner beat with lock=0 releases the lock. last_src = owner.
//  MUX2_ARB_BURST_EN undefined:
//   - No lock ports, no lock owner register. Pure round-robin per beat.
// STRUCTURE
//  - Package mux2_arb_pkg holds:
//      typedef enum logic {EMPTY, FULL} arb_state_t;
//      localparam SRC_A = 1'b1, SRC_B = 1'b0.
//  - One sub-module: mux2 #(.n(n)) selects a_data/b_data with select=grant_A. It feeds the out_data register.
//  - Arbitration, FSM and lock logic live in this module.
// TESTING
//  1. Reset: hold rst_n=0 with a_valid=b_valid=1 -> all outputs 0. Release -> A granted first, out_src=1 next cycle.
//  2. Alternation: both valid continuously, out_ready=1, A=0x1111, B=0x2222 -> out_data sequence 1111,2222,1111,... one per cycle.
//  3. Backpressure: out_ready=0 with FULL holding 0xAAAA -> a_ready=b_ready=0, out_data stays 0xAAAA.
//     Raise out_ready -> next beat loads the same cycle (no bubble).
//  4. Single requester: only B valid for 4 cycles, out_ready=1 -> 4 B beats, a_ready never 1.
//     A then arrives alone -> granted immediately.
//  5. Reset mid-operation: assert rst_n=0 asynchronously while FULL -> out_valid drops before the next clk edge.
//     After release, the previous beat is not replayed.
//  6. [MUX2_ARB_BURST_EN] A sends 3 beats with lock=1,1,0 while B valid throughout.
//     -> A,A,A, then B; b_ready=0 during the lock even when a_valid gaps.

Source files
------------

// File: rtl/mux2_arb_pkg.sv
// rtl/mux2_arb_pkg.sv - shared state and source encodings for the two-requester round-robin arbiter
package mux2_arb_pkg;

    typedef enum logic {EMPTY, FULL} arb_state_t;

    localparam logic SRC_A = 1'b1;
    localparam logic SRC_B = 1'b0;

endpackage

// File: rtl/mux2_rr_arbiter_mux2.sv
// rtl/mux2_rr_arbiter_mux2.sv - n-bit 2:1 datapath mux, select=1 picks a
module mux2 #(
    parameter int n = 16
) (
    input  logic         select,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] y
);

    assign y = select ? a : b;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - round-robin arbiter sharing one registered 2:1 mux between requesters A and B
// Optional burst locking via MUX2_ARB_BURST_EN (adds a_lock/b_lock ports and a lock owner).
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         a_valid,
    input  logic [n-1:0] a_data,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [n-1:0] b_data,
    output logic         b_ready,
    output logic         out_valid,
    output logic [n-1:0] out_data,
    output logic         out_src,
`ifdef MUX2_ARB_BURST_EN
    input  logic         a_lock,
    input  logic         b_lock,
`endif
    input  logic         out_ready
);

    arb_state_t   state;
    logic         last_src;
    logic         a_elig;
    logic         b_elig;
    logic         grant_a;
    logic         grant_b;
    logic         can_load;
    logic         load_en;
    logic [n-1:0] mux_data;

`ifdef MUX2_ARB_BURST_EN
    logic lock_held;
    logic lock_owner;

    // While a lock is held only the owner may be granted, even when it is idle.
    assign a_elig = a_valid & (~lock_held | (lock_owner == SRC_A));
    assign b_elig = b_valid & (~lock_held | (lock_owner == SRC_B));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_held  <= 1'b0;
            lock_owner <= SRC_B;
        end else if (load_en) begin
            lock_held  <= grant_a ? a_lock : b_lock;
            lock_owner <= grant_a ? SRC_A : SRC_B;
        end
    end
`else
    assign a_elig = a_valid;
    assign b_elig = b_valid;
`endif

    // On a tie the requester that did not win last time goes first.
    assign grant_a = a_elig & (~b_elig | (last_src == SRC_B));
    assign grant_b = b_elig & (~a_elig | (last_src == SRC_A));

    assign can_load = (state == EMPTY) | out_ready;
    assign load_en  = (grant_a | grant_b) & can_load;

    assign a_ready   = rst_n & grant_a & can_load;
    assign b_ready   = rst_n & grant_b & can_load;
    assign out_valid = (state == FULL);

    mux2 #(.n(n)) u_mux (
        .select (grant_a),
        .a      (a_data),
        .b      (b_data),
        .y      (mux_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            out_src  <= SRC_B;
            last_src <= SRC_B;
        end else if (load_en) begin
            state    <= FULL;
            out_data <= mux_data;
            out_src  <= grant_a;
            last_src <= grant_a ? SRC_A : SRC_B;
        end else if (out_ready) begin
            state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb/tb_mux2_rr_arbiter.sv - self-checking bench for mux2_rr_arbiter against a beat-level reference model
module tb_mux2_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0;
    logic [15:0] a_data = '0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [15:0] b_data = '0;
    logic        b_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_src;
    logic        out_ready = 1'b0;
`ifdef MUX2_ARB_BURST_EN
    logic        a_lock = 1'b0;
    logic        b_lock = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: what the output register holds and who won last.
    logic        m_full = 1'b0;
    logic [15:0] m_data = '0;
    logic        m_src = 1'b0;
    logic        m_last_a = 1'b0;
    logic        m_own_v = 1'b0;
    logic        m_own_a = 1'b0;
    logic        last_a_acc = 1'b0;
    logic        last_b_acc = 1'b0;

    mux2_rr_arbiter #(.n(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
`ifdef MUX2_ARB_BURST_EN
        .a_lock    (a_lock),
        .b_lock    (b_lock),
`endif
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0; m_data = '0; m_src = 1'b0; m_last_a = 1'b0;
        m_own_v = 1'b0; m_own_a = 1'b0; last_a_acc = 1'b0; last_b_acc = 1'b0;
    endtask

    // Check one cycle at the falling edge, then advance the model across the rising edge.
    task automatic cycle(input string tag);
        logic a_ok, b_ok, ga, gb, can, lk;
        @(negedge clk);
        a_ok = a_valid;
        b_ok = b_valid;
`ifdef MUX2_ARB_BURST_EN
        if (m_own_v) begin
            a_ok = a_valid && m_own_a;
            b_ok = b_valid && !m_own_a;
        end
`endif
        if (a_ok && b_ok) begin
            ga = !m_last_a;
            gb = m_last_a;
        end else begin
            ga = a_ok;
            gb = b_ok;
        end
        can = !m_full || out_ready;
        chk({tag, "_a_ready"}, a_ready, ga && can);
        chk({tag, "_b_ready"}, b_ready, gb && can);
        chk({tag, "_both_ready"}, a_ready && b_ready, 1'b0);
        chk({tag, "_out_valid"}, out_valid, m_full);
        if (m_full) begin
            chk({tag, "_out_data"}, out_data, m_data);
            chk({tag, "_out_src"}, out_src, m_src);
        end
        last_a_acc = ga && can;
        last_b_acc = gb && can;
        if ((ga || gb) && can) begin
            m_full   = 1'b1;
            m_data   = ga ? a_data : b_data;
            m_src    = ga;
            m_last_a = ga;
`ifdef MUX2_ARB_BURST_EN
            lk = ga ? a_lock : b_lock;
            if (lk) begin
                m_own_v = 1'b1;
                m_own_a = ga;
            end else if (m_own_v && (m_own_a == ga)) begin
                m_own_v = 1'b0;
            end
`else
            lk = 1'b0;
`endif
        end else if (m_full && out_ready) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1. Reset with both requesters valid
        a_valid = 1'b1; a_data = 16'h1111;
        b_valid = 1'b1; b_data = 16'h2222;
        out_ready = 1'b1;
        #12;
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_b_ready", b_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 16'h0);
        chk("rst_out_src", out_src, 1'b0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle("rel");
        chk("rel_first_src_is_a", out_src, 1'b1);
        chk("rel_first_data", out_data, 16'h1111);

        // 2. Alternation, one beat per cycle
        for (int i = 0; i < 6; i++) begin
            cycle("alt");
            chk("alt_seq", out_data, (i % 2 == 0) ? 16'h2222 : 16'h1111);
        end

        // 3. Backpressure
        a_valid = 1'b0; b_valid = 1'b0;
        cycle("bp_drain");
        a_valid = 1'b1; a_data = 16'hAAAA; out_ready = 1'b0;
        cycle("bp_load");
        a_data = 16'h1234; b_valid = 1'b1; b_data = 16'h5678;
        for (int i = 0; i < 3; i++) begin
            cycle("bp_hold");
            chk("bp_hold_data", out_data, 16'hAAAA);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", a_ready | b_ready, 1'b1);
        cycle("bp_release");
        cycle("bp_after");

        // 4. Single requester
        a_valid = 1'b0; b_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_data = 16'hB000 + 16'(i);
            cycle("b_only");
        end
        b_valid = 1'b0; a_valid = 1'b1; a_data = 16'hA5A5;
        cycle("a_alone");
        a_valid = 1'b0;
        cycle("a_alone_out");

        // 5. Asynchronous reset while FULL
        a_valid = 1'b1; a_data = 16'hBEEF; out_ready = 1'b0;
        cycle("pre_rst");
        chk("pre_rst_full", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_a_ready", a_ready, 1'b0);
        chk("async_rst_out_data", out_data, 16'h0);
        model_reset();
        a_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle("post_rst");
        cycle("post_rst2");

`ifdef MUX2_ARB_BURST_EN
        // 6. Locked burst from A with a gap while B waits
        b_valid = 1'b1; b_data = 16'h2222;
        a_valid = 1'b1; a_data = 16'hA001; a_lock = 1'b1;
        cycle("lk1");
        a_data = 16'hA002;
        cycle("lk2");
        a_valid = 1'b0;
        cycle("lk_gap");
        chk("lk_gap_b_blocked", last_b_acc, 1'b0);
        a_valid = 1'b1; a_data = 16'hA003; a_lock = 1'b0;
        cycle("lk3");
        a_valid = 1'b0;
        cycle("lk_b");
        chk("lk_b_wins", out_src, 1'b0);
        b_valid = 1'b0;
        cycle("lk_end");
`endif

        // Randomized phase honouring hold-until-ready
        for (int i = 0; i < 400; i++) begin
            if (!(a_valid && !last_a_acc)) begin
                a_valid = 1'($urandom_range(0, 1));
                a_data = 16'($urandom);
`ifdef MUX2_ARB_BURST_EN
                a_lock = ($urandom_range(0, 3) == 0);
`endif
            end
            if (!(b_valid && !last_b_acc)) begin
                b_valid = 1'($urandom_range(0, 1));
                b_data = 16'($urandom);
`ifdef MUX2_ARB_BURST_EN
                b_lock = ($urandom_range(0, 3) == 0);
`endif
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
